mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
Controller that sequences one MAC datapath instance to compute a dot product of VEC_LEN operand pairs. Accepts a start command, clears the accumulator, and streams operand pairs into the MAC under a valid/ready handshake. It then waits out the MAC output latency and presents the result under a result valid/ready handshake. It sits between an operand source (memory reader or DMA) and the MAC, and owns the MAC's SCLR, LOAD, A and B pins.

Parameters:
IN1_WIDTH, 8, width of operand A / MAC A port
IN2_WIDTH, 8, width of operand B / MAC B port
OUT_WIDTH, 20, width of MAC_OUT and RESULT
LEN_WIDTH, 5, width of VEC_LEN; max vector length 2**LEN_WIDTH-1
MAC_LATENCY, 1, cycles from the clock edge sampling MAC_LOAD=1 until MAC_OUT includes that product (1..4)

Ports:
SYS_CLK  in  1  system clock; all logic on the rising edge
SCLR  in  1  synchronous active-high reset
START  in  1  command strobe; sampled only in IDLE
VEC_LEN  in  LEN_WIDTH  number of pairs; latched when START is accepted
ABORT  in  1  cancel current operation
IN_A  in  IN1_WIDTH  operand A
IN_B  in  IN2_WIDTH  operand B
IN_VALID  in  1  operand pair valid
IN_READY  out  1  controller accepts a pair this cycle
MAC_SCLR  out  1  to MAC SCLR
MAC_LOAD  out  1  to MAC LOAD
MAC_A  out  IN1_WIDTH  to MAC A
MAC_B  out  IN2_WIDTH  to MAC B
MAC_OUT  in  OUT_WIDTH  from MAC output
RESULT  out  OUT_WIDTH  captured dot product
RESULT_VALID  out  1  RESULT holds a valid dot product
RESULT_READY  in  1  consumer takes RESULT
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset: SCLR=1 forces state IDLE. Counters=0, RESULT=0, RESULT_VALID=0, IN_READY=0, MAC_LOAD=0, BUSY=0. MAC_SCLR=1 during reset (SCLR is ORed into MAC_SCLR). Reset mid-operation discards everything; no result is produced.
- States: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE: START=1 latches VEC_LEN into LEN_R, sets count=0, and moves to CLEAR. START in any other state is ignored.
- CLEAR (exactly 1 cycle): MAC_SCLR=1, MAC_LOAD=0. Next state is ACCUM if LEN_R!=0, otherwise DRAIN.
- ACCUM: IN_READY=1.
  - MAC_A=IN_A, MAC_B=IN_B, MAC_LOAD=IN_VALID (combinational pass-through, zero added latency).
  - A transfer occurs on IN_VALID&IN_READY and increments count.
  - A transfer with count==LEN_R-1 moves to DRAIN.
  - IN_VALID=0 cycles are bubbles: MAC_LOAD=0 and the accumulator holds.
- Outside ACCUM: IN_READY=0, MAC_LOAD=0, MAC_A=MAC_B=0.
- DRAIN: wait counter loaded with MAC_LATENCY, decrements each cycle. In the cycle it reads 0: RESULT<=MAC_OUT, RESULT_VALID<=1, move to DONE. The first DRAIN cycle already counts.
- Latency: the last operand accepted at edge N gives RESULT_VALID=1 after edge N+MAC_LATENCY+1.
- DONE: RESULT and RESULT_VALID are held stable until RESULT_READY=1, then the controller returns to IDLE on the next edge. START in the same cycle as RESULT_READY is ignored; the minimum spacing between results is 1 IDLE cycle.
- ABORT: from CLEAR/ACCUM/DRAIN/DONE, the next state is IDLE.
  - MAC_SCLR=1 in the abort cycle; no transfer is accepted that cycle (IN_READY=0 when ABORT=1).
  - RESULT_VALID is cleared; RESULT keeps its old value.
  - ABORT in IDLE has no effect.
- Simultaneous events: SCLR > ABORT > START.
- Arithmetic: the controller does no arithmetic on data. Overflow and wrap of MAC_OUT are the MAC's behaviour and are passed through unchanged.
- The LEN_R count compare is at full LEN_WIDTH. VEC_LEN=2**LEN_WIDTH-1 is legal.

Test Plan:
- Basic: VEC_LEN=4, pairs (3,1),(4,1),(5,1),(6,1) streamed back-to-back -> one CLEAR cycle with MAC_SCLR=1, 4 LOAD cycles, RESULT=18, RESULT_VALID MAC_LATENCY+1 edges after the last transfer.
- Bubbles: VEC_LEN=3, pairs (2,3),(4,5),(1,7) with IN_VALID low for 2 cycles between each -> MAC_LOAD only on transfer cycles, RESULT=33.
- Zero length: VEC_LEN=0 -> CLEAR, DRAIN, then RESULT=0; no IN_READY assertion ever.
- Back-pressure: RESULT_READY held low 5 cycles after RESULT_VALID -> RESULT stable, BUSY=1; START pulsed during DONE is ignored; after RESULT_READY, IDLE, and a new START is accepted.
- Abort: VEC_LEN=8, ABORT after 3 transfers -> MAC_SCLR=1 that cycle, IDLE next, no RESULT_VALID. A following VEC_LEN=2 run with (5,5),(1,1) gives RESULT=26.
- Reset mid-DRAIN: SCLR=1 for 1 cycle -> all outputs at reset values, MAC_SCLR=1, no result; START afterward completes normally.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Sequences one MAC datapath through a dot product of VEC_LEN operand pairs:
//   clears the accumulator, streams operand pairs into the MAC under a
//   valid/ready handshake, waits out the MAC output latency, then presents the
//   captured accumulator value under a result valid/ready handshake.
//
// Ports
//   SYS_CLK, SCLR             clock, synchronous active-high reset
//   START, VEC_LEN            command strobe and pair count (latched in IDLE)
//   ABORT                     cancel the current operation
//   IN_A, IN_B, IN_VALID      operand pair stream in
//   IN_READY                  pair accepted this cycle (with IN_VALID)
//   MAC_SCLR, MAC_LOAD        MAC control pins
//   MAC_A, MAC_B              MAC operand pins (pass-through in ACCUM)
//   MAC_OUT                   MAC accumulator output
//   RESULT, RESULT_VALID      captured dot product and its valid flag
//   RESULT_READY              consumer takes RESULT
//   BUSY                      any state other than IDLE

module mac_dot_sequencer #(
    parameter int unsigned IN1_WIDTH   = 8,
    parameter int unsigned IN2_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH   = 20,
    parameter int unsigned LEN_WIDTH   = 5,
    parameter int unsigned MAC_LATENCY = 1
) (
    input  logic                 SYS_CLK,
    input  logic                 SCLR,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] VEC_LEN,
    input  logic                 ABORT,
    input  logic [IN1_WIDTH-1:0] IN_A,
    input  logic [IN2_WIDTH-1:0] IN_B,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic                 MAC_SCLR,
    output logic                 MAC_LOAD,
    output logic [IN1_WIDTH-1:0] MAC_A,
    output logic [IN2_WIDTH-1:0] MAC_B,
    input  logic [OUT_WIDTH-1:0] MAC_OUT,
    output logic [OUT_WIDTH-1:0] RESULT,
    output logic                 RESULT_VALID,
    input  logic                 RESULT_READY,
    output logic                 BUSY
);

    localparam int unsigned WaitWidth = 3;
    localparam logic [LEN_WIDTH-1:0] LenOne  = LEN_WIDTH'(1);
    localparam logic [WaitWidth-1:0] WaitOne = WaitWidth'(1);

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StDone} state_e;

    state_e               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] count_q;
    logic [WaitWidth-1:0] wait_q;
    logic [OUT_WIDTH-1:0] result_q;
    logic                 result_valid_q;

    logic in_accum;
    logic abort_act;
    logic xfer;

    // SCLR is folded in so nothing reaches the MAC during a reset cycle.
    assign in_accum  = (state_q == StAccum) && !SCLR;
    assign abort_act = ABORT && (state_q != StIdle);
    assign IN_READY  = in_accum && !ABORT;
    assign xfer      = IN_READY && IN_VALID;

    assign MAC_LOAD     = xfer;
    assign MAC_A        = in_accum ? IN_A : '0;
    assign MAC_B        = in_accum ? IN_B : '0;
    assign MAC_SCLR     = SCLR || (state_q == StClear) || abort_act;
    assign BUSY         = (state_q != StIdle);
    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;

    always_ff @(posedge SYS_CLK) begin
        if (SCLR) begin
            state_q        <= StIdle;
            len_q          <= '0;
            count_q        <= '0;
            wait_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (abort_act) begin
            // RESULT deliberately keeps its previous value.
            state_q        <= StIdle;
            count_q        <= '0;
            result_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        len_q   <= VEC_LEN;
                        count_q <= '0;
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    // Loaded here so it is ready whichever way DRAIN is entered.
                    wait_q  <= WaitWidth'(MAC_LATENCY);
                    state_q <= (len_q != '0) ? StAccum : StDrain;
                end
                StAccum: begin
                    if (xfer) begin
                        count_q <= count_q + LenOne;
                        if (count_q == len_q - LenOne) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (wait_q == '0) begin
                        result_q       <= MAC_OUT;
                        result_valid_q <= 1'b1;
                        state_q        <= StDone;
                    end else begin
                        wait_q <= wait_q - WaitOne;
                    end
                end
                StDone: begin
                    if (RESULT_READY) begin
                        result_valid_q <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

    localparam int W1  = 8;
    localparam int W2  = 8;
    localparam int WO  = 20;
    localparam int LW  = 5;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          sclr, start, abort, in_valid, in_ready;
    logic [LW-1:0] vec_len;
    logic [W1-1:0] in_a, mac_a;
    logic [W2-1:0] in_b, mac_b;
    logic          mac_sclr, mac_load, result_valid, result_ready, busy;
    logic [WO-1:0] mac_out, result;

    always #5 clk = ~clk;

    mac_dot_sequencer #(
        .IN1_WIDTH(W1), .IN2_WIDTH(W2), .OUT_WIDTH(WO), .LEN_WIDTH(LW), .MAC_LATENCY(LAT)
    ) dut (
        .SYS_CLK(clk), .SCLR(sclr), .START(start), .VEC_LEN(vec_len), .ABORT(abort),
        .IN_A(in_a), .IN_B(in_b), .IN_VALID(in_valid), .IN_READY(in_ready),
        .MAC_SCLR(mac_sclr), .MAC_LOAD(mac_load), .MAC_A(mac_a), .MAC_B(mac_b),
        .MAC_OUT(mac_out), .RESULT(result), .RESULT_VALID(result_valid),
        .RESULT_READY(result_ready), .BUSY(busy)
    );

    // Behavioural MAC: accumulator followed by LAT-1 output stages.
    logic [WO-1:0] stg [LAT];
    always @(posedge clk) begin
        if (mac_sclr) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else begin
            if (mac_load) stg[0] <= stg[0] + WO'(mac_a) * WO'(mac_b);
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
    end
    assign mac_out = stg[LAT-1];

    int cyc = 0;
    int loads = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_load === 1'b1) loads <= loads + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W1-1:0] op_a [32];
    logic [W2-1:0] op_b [32];
    int loads0;

    task automatic start_op(input int len, input string name);
        start   = 1'b1;
        vec_len = LW'(len);
        loads0  = loads;
        step();
        start   = 1'b0;
        #1;
        chk({name, "_clear_sclr"}, 32'(mac_sclr), 1);
        chk({name, "_clear_busy"}, 32'(busy), 1);
    endtask

    // Streams up to nmax pairs with 'gap' idle cycles after each transfer.
    task automatic stream(input int len, input int gap, input int nmax, input string name,
                          output int last_edge);
        int sent = 0;
        int idle = 0;
        int guard = 0;
        bit pass_ok = 1'b1;
        last_edge = cyc + 1;
        while (sent < nmax && guard < 400) begin
            in_valid = (idle == 0);
            in_a = op_a[sent];
            in_b = op_b[sent];
            #1;
            if (in_valid && in_ready) begin
                if (mac_a !== op_a[sent] || mac_b !== op_b[sent] || mac_load !== 1'b1)
                    pass_ok = 1'b0;
                sent++;
                last_edge = cyc + 1;
                idle = gap;
            end else begin
                if (mac_load !== 1'b0) pass_ok = 1'b0;
                if (!in_valid) idle--;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        chk({name, "_stream_done"}, 32'(sent), 32'(nmax));
        chk({name, "_passthru"}, 32'(pass_ok), 1);
    endtask

    task automatic finish_op(input int len, input int last_edge, input logic [WO-1:0] exp,
                             input int rdy_delay, input string name);
        int guard = 0;
        bit quiet = 1'b1;
        #1;
        while (!result_valid && guard < 100) begin
            if (in_ready !== 1'b0 || mac_load !== 1'b0) quiet = 1'b0;
            step();
            #1;
            guard++;
        end
        chk({name, "_valid"}, 32'(result_valid), 1);
        chk({name, "_latency"}, 32'(cyc), 32'(last_edge + LAT + 1));
        chk({name, "_result"}, 32'(result), 32'(exp));
        chk({name, "_loads"}, 32'(loads - loads0), 32'(len));
        chk({name, "_quiet"}, 32'(quiet), 1);
        for (int k = 0; k < rdy_delay; k++) begin
            start = (k == 1);
            vec_len = 5'd3;
            step();
            start = 1'b0;
            #1;
            chk({name, "_hold_result"}, 32'(result), 32'(exp));
            chk({name, "_hold_valid"}, 32'(result_valid & busy), 1);
        end
        result_ready = 1'b1;
        start = 1'b1;  // must be ignored alongside RESULT_READY
        step();
        result_ready = 1'b0;
        start = 1'b0;
        #1;
        chk({name, "_idle_busy"}, 32'(busy), 0);
        chk({name, "_idle_valid"}, 32'(result_valid), 0);
        step();
        chk({name, "_still_idle"}, 32'(busy), 0);
    endtask

    typedef struct {
        int len;
        int gap;
        int rdy;
        int a [4];
        int b [4];
        int exp;
        string name;
    } vec_t;

    vec_t tbl [4];

    task automatic set_vec(input int i, input int len, input int gap, input int rdy,
                           input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input int exp, input string name);
        tbl[i].len = len; tbl[i].gap = gap; tbl[i].rdy = rdy;
        tbl[i].a[0] = a0; tbl[i].a[1] = a1; tbl[i].a[2] = a2; tbl[i].a[3] = a3;
        tbl[i].b[0] = b0; tbl[i].b[1] = b1; tbl[i].b[2] = b2; tbl[i].b[3] = b3;
        tbl[i].exp = exp; tbl[i].name = name;
    endtask

    task automatic run_op(input int len, input int gap, input int rdy, input logic [WO-1:0] exp,
                          input string name);
        int le;
        start_op(len, name);
        stream(len, gap, len, name, le);
        finish_op(len, le, exp, rdy, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int le;
        int sum;
        int len;
        bit saw_valid;
        sclr = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; vec_len = '0;
        in_a = 8'h55; in_b = 8'haa; result_ready = 1'b0;
        step();
        step();
        chk("rst_mac_sclr", 32'(mac_sclr), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mac_load", 32'(mac_load), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_result", 32'(result), 0);
        sclr = 1'b0;
        in_valid = 1'b0;
        step();

        set_vec(0, 4, 0, 0, 3, 4, 5, 6, 1, 1, 1, 1, 18, "basic");
        set_vec(1, 3, 2, 0, 2, 4, 1, 0, 3, 5, 7, 0, 33, "bubbles");
        set_vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "zero_len");
        set_vec(3, 4, 0, 5, 3, 4, 5, 6, 1, 1, 1, 1, 18, "backpressure");
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = W1'(tbl[t].a[i]);
                op_b[i] = W2'(tbl[t].b[i]);
            end
            run_op(tbl[t].len, tbl[t].gap, tbl[t].rdy, WO'(tbl[t].exp), tbl[t].name);
        end

        // Abort after 3 of 8 transfers.
        for (int i = 0; i < 8; i++) begin op_a[i] = 8'd9; op_b[i] = 8'd9; end
        start_op(8, "abort");
        stream(8, 0, 3, "abort", le);
        abort = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("abort_mac_sclr", 32'(mac_sclr), 1);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_mac_load", 32'(mac_load), 0);
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle", 32'(busy), 0);
        chk("abort_keep_result", 32'(result), 18);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (result_valid !== 1'b0) saw_valid = 1'b1;
            step();
        end
        chk("abort_no_valid", 32'(saw_valid), 0);
        op_a[0] = 8'd5; op_b[0] = 8'd5; op_a[1] = 8'd1; op_b[1] = 8'd1;
        run_op(2, 0, 0, 20'd26, "after_abort");

        // Reset in the first DRAIN cycle.
        op_a[0] = 8'd7; op_b[0] = 8'd7; op_a[1] = 8'd2; op_b[1] = 8'd3;
        start_op(2, "rst_drain");
        stream(2, 0, 2, "rst_drain", le);
        sclr = 1'b1;
        #1;
        chk("rst_drain_mac_sclr", 32'(mac_sclr), 1);
        step();
        sclr = 1'b0;
        chk("rst_drain_busy", 32'(busy), 0);
        chk("rst_drain_result", 32'(result), 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (result_valid !== 1'b0) saw_valid = 1'b1;
            step();
        end
        chk("rst_drain_no_valid", 32'(saw_valid), 0);
        run_op(2, 0, 0, 20'd55, "after_rst");

        // Random runs against an arithmetic reference; last one is full length.
        for (int r = 0; r < 12; r++) begin
            len = (r == 11) ? 31 : int'($urandom_range(0, 31));
            sum = 0;
            for (int i = 0; i < len; i++) begin
                op_a[i] = W1'($urandom);
                op_b[i] = W2'($urandom);
                sum = sum + int'(op_a[i]) * int'(op_b[i]);
            end
            run_op(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   WO'(sum % (1 << WO)), $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
